fg_config_loader: RTL and testbench

FG_CONFIG_LOADER -- requirements
Module: fg_config_loader

---
 rtl/fg_config_loader.sv | 218 +++++++++++++++++++++
 tb/tb_fg_config_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fg_config_loader.sv
// fg_config_loader: byte-stream loader and readback for the generator config word.
// Ports: clk_i/rst_n (sync, active-low), rx byte stream in (rxData_i/rxValid_i/rxReady_o),
// tx byte stream out (txData_o/txValid_o/txReady_i), CR_bus_o committed word,
// commit_o/error_o one-cycle pulses, errCode_o last error (0 none,1 chk,2 timeout,3 cmd).
module fg_config_loader #(
    parameter int CONFIG_REG_BITWIDTH = 64,
    parameter int TIMEOUT_CYCLES      = 1023,
    parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    input  logic [7:0]                     rxData_i,
    input  logic                           rxValid_i,
    output logic                           rxReady_o,
    output logic [7:0]                     txData_o,
    output logic                           txValid_o,
    input  logic                           txReady_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           commit_o,
    output logic                           error_o,
    output logic [1:0]                     errCode_o
);
    localparam int W      = CONFIG_REG_BITWIDTH;
    localparam int NBYTES = W / 8;
    localparam int BCW    = $clog2(NBYTES) + 1;
    localparam int ICW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [ICW-1:0] IDLE_HIT  = ICW'(TIMEOUT_CYCLES - 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WCHK,
        RDATA,
        RCHK
    } state_t;

    state_t state, state_next;

    logic [W-1:0]   shadow;
    logic [7:0]     run_xor;
    logic [BCW-1:0] byte_cnt;
    logic [ICW-1:0] idle_cnt;

    logic       rx_fire, tx_fire;
    logic       start_w, start_r;
    logic       shift_en, commit_en, err_en;
    logic [1:0] err_code_set;
    logic       cnt_clr, cnt_inc;
    logic       idle_clr, idle_inc;
    logic       timeout_hit;
    logic [W-1:0] rd_word;
    logic [7:0]   cr_xor;

    assign rx_fire     = rxValid_i && rxReady_o;
    assign tx_fire     = txValid_o && txReady_i;
    assign timeout_hit = (idle_cnt >= IDLE_HIT);

    // Readback byte k is the k-th byte from the MSB end of the live word.
    always_comb begin
        rd_word = CR_bus_o << {byte_cnt, 3'b000};
        cr_xor  = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            cr_xor = cr_xor ^ CR_bus_o[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        rxReady_o    = 1'b0;
        txValid_o    = 1'b0;
        txData_o     = 8'h00;
        start_w      = 1'b0;
        start_r      = 1'b0;
        shift_en     = 1'b0;
        commit_en    = 1'b0;
        err_en       = 1'b0;
        err_code_set = 2'd0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        idle_clr     = 1'b0;
        idle_inc     = 1'b0;
        unique case (state)
            IDLE: begin
                rxReady_o = 1'b1;
                if (rx_fire) begin
                    if (rxData_i == 8'hA5) begin
                        state_next = WDATA;
                        start_w    = 1'b1;
                    end else if (rxData_i == 8'h5A) begin
                        state_next = RDATA;
                        start_r    = 1'b1;
                    end else begin
                        err_en       = 1'b1;
                        err_code_set = 2'd3;
                    end
                end
            end
            WDATA: begin
                rxReady_o = 1'b1;
                if (rx_fire) begin
                    shift_en = 1'b1;
                    idle_clr = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = WCHK;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next   = IDLE;
                    err_en       = 1'b1;
                    err_code_set = 2'd2;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            WCHK: begin
                rxReady_o = 1'b1;
                if (rx_fire) begin
                    state_next = IDLE;
                    idle_clr   = 1'b1;
                    if (rxData_i == run_xor) begin
                        commit_en = 1'b1;
                    end else begin
                        err_en       = 1'b1;
                        err_code_set = 2'd1;
                    end
                end else if (timeout_hit) begin
                    state_next   = IDLE;
                    err_en       = 1'b1;
                    err_code_set = 2'd2;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            RDATA: begin
                txValid_o = 1'b1;
                txData_o  = rd_word[W-1 -: 8];
                if (tx_fire) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_next = RCHK;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            RCHK: begin
                txValid_o = 1'b1;
                txData_o  = cr_xor;
                if (tx_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            CR_bus_o  <= RESET_CONFIG;
            shadow    <= '0;
            run_xor   <= 8'h00;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            commit_o  <= 1'b0;
            error_o   <= 1'b0;
            errCode_o <= 2'd0;
        end else begin
            commit_o <= commit_en;
            error_o  <= err_en;

            if (err_en) begin
                errCode_o <= err_code_set;
            end else if (start_w || start_r) begin
                errCode_o <= 2'd0;
            end

            if (commit_en) begin
                CR_bus_o <= shadow;
            end

            // A failed frame drops whatever was collected so far.
            if (start_w || err_en) begin
                shadow  <= '0;
                run_xor <= 8'h00;
            end else if (shift_en) begin
                shadow  <= (shadow << 8) | W'(rxData_i);
                run_xor <= run_xor ^ rxData_i;
            end

            if (start_w || start_r || cnt_clr) begin
                byte_cnt <= '0;
            end else if (cnt_inc) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (start_w || idle_clr) begin
                idle_cnt <= '0;
            end else if (idle_inc && idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fg_config_loader.sv
// tb_fg_config_loader: directed self-checking bench for fg_config_loader.
// Covers reset, write/commit, bad checksum, readback stall, timeout, bad command, mid-frame reset.
module tb_fg_config_loader;
    localparam logic [63:0] RST_CFG = 64'h1122_3344_5566_7788;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [7:0]  rxData_i;
    logic        rxValid_i;
    logic        rxReady_o;
    logic [7:0]  txData_o;
    logic        txValid_o;
    logic        txReady_i;
    logic [63:0] CR_bus_o;
    logic        commit_o;
    logic        error_o;
    logic [1:0]  errCode_o;

    int total = 0;
    int bad   = 0;

    fg_config_loader #(
        .CONFIG_REG_BITWIDTH(64),
        .TIMEOUT_CYCLES(16),
        .RESET_CONFIG(RST_CFG)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .rxData_i(rxData_i),
        .rxValid_i(rxValid_i),
        .rxReady_o(rxReady_o),
        .txData_o(txData_o),
        .txValid_o(txValid_o),
        .txReady_i(txReady_i),
        .CR_bus_o(CR_bus_o),
        .commit_o(commit_o),
        .error_o(error_o),
        .errCode_o(errCode_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rxData_i  = b;
        rxValid_i = 1'b1;
        tick();
        rxValid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++; if (CR_bus_o !== RST_CFG) begin bad++; $display("FAIL rst_cr: got %h want %h", CR_bus_o, RST_CFG); end
        total++; if (commit_o !== 1'b0) begin bad++; $display("FAIL rst_commit: got %b want 0", commit_o); end
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error_o); end
        total++; if (errCode_o !== 2'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", errCode_o); end
        total++; if (txValid_o !== 1'b0 || txData_o !== 8'h00) begin bad++; $display("FAIL rst_tx: got v=%b d=%h want v=0 d=00", txValid_o, txData_o); end
        total++; if (rxReady_o !== 1'b1) begin bad++; $display("FAIL rst_rxready: got %b want 1", rxReady_o); end
    endtask

    task automatic test_write();
        send(8'hA5);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i));
            total++; if (commit_o !== 1'b0 || CR_bus_o !== RST_CFG) begin bad++; $display("FAIL wr_partial%0d: got c=%b cr=%h want c=0 cr=%h", i, commit_o, CR_bus_o, RST_CFG); end
        end
        send(8'h08);
        total++; if (commit_o !== 1'b1) begin bad++; $display("FAIL wr_commit: got %b want 1", commit_o); end
        total++; if (CR_bus_o !== 64'h0102_0304_0506_0708) begin bad++; $display("FAIL wr_cr: got %h want 0102030405060708", CR_bus_o); end
        total++; if (error_o !== 1'b0 || errCode_o !== 2'd0) begin bad++; $display("FAIL wr_err: got e=%b c=%0d want e=0 c=0", error_o, errCode_o); end
        tick();
        total++; if (commit_o !== 1'b0) begin bad++; $display("FAIL wr_pulse: got %b want 0", commit_o); end
    endtask

    task automatic test_bad_checksum();
        send(8'hA5);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h00);
        total++; if (error_o !== 1'b1 || commit_o !== 1'b0) begin bad++; $display("FAIL chk_err: got e=%b c=%b want e=1 c=0", error_o, commit_o); end
        total++; if (errCode_o !== 2'd1) begin bad++; $display("FAIL chk_code: got %0d want 1", errCode_o); end
        total++; if (CR_bus_o !== 64'h0102_0304_0506_0708) begin bad++; $display("FAIL chk_cr: got %h want 0102030405060708", CR_bus_o); end
        tick();
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL chk_pulse: got %b want 0", error_o); end
    endtask

    task automatic test_readback();
        logic [7:0] exp [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        send(8'h5A);
        // Offer a stray command byte while busy; it must not be taken.
        rxData_i  = 8'hA5;
        rxValid_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            txReady_i = 1'b0;
            total++; if (txValid_o !== 1'b1 || txData_o !== exp[k]) begin bad++; $display("FAIL rb_byte%0d: got v=%b d=%h want v=1 d=%h", k, txValid_o, txData_o, exp[k]); end
            total++; if (rxReady_o !== 1'b0) begin bad++; $display("FAIL rb_rxready%0d: got %b want 0", k, rxReady_o); end
            tick();
            total++; if (txData_o !== exp[k]) begin bad++; $display("FAIL rb_stall%0d: got %h want %h", k, txData_o, exp[k]); end
            txReady_i = 1'b1;
            tick();
            if (k == 8) rxValid_i = 1'b0;
        end
        txReady_i = 1'b0;
        total++; if (txValid_o !== 1'b0 || rxReady_o !== 1'b1) begin bad++; $display("FAIL rb_done: got v=%b r=%b want v=0 r=1", txValid_o, rxReady_o); end
        total++; if (CR_bus_o !== 64'h0102_0304_0506_0708 || commit_o !== 1'b0) begin bad++; $display("FAIL rb_cr: got %h c=%b want 0102030405060708 c=0", CR_bus_o, commit_o); end
    endtask

    task automatic test_timeout();
        logic [7:0] d [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send(8'hA5);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) begin
                total++; if (error_o !== 1'b0) begin bad++; $display("FAIL to_early%0d: got %b want 0", i, error_o); end
            end
        end
        total++; if (error_o !== 1'b1 || errCode_o !== 2'd2) begin bad++; $display("FAIL to_hit: got e=%b c=%0d want e=1 c=2", error_o, errCode_o); end
        total++; if (CR_bus_o !== 64'h0102_0304_0506_0708) begin bad++; $display("FAIL to_cr: got %h want 0102030405060708", CR_bus_o); end
        send(8'hA5);
        total++; if (errCode_o !== 2'd0 || error_o !== 1'b0) begin bad++; $display("FAIL to_clear: got c=%0d e=%b want c=0 e=0", errCode_o, error_o); end
        for (int i = 0; i < 8; i++) send(d[i]);
        send(8'h80);
        total++; if (commit_o !== 1'b1 || CR_bus_o !== 64'h1020_3040_5060_7080) begin bad++; $display("FAIL to_recover: got c=%b cr=%h want c=1 cr=1020304050607080", commit_o, CR_bus_o); end
    endtask

    task automatic test_bad_cmd();
        send(8'h3C);
        total++; if (error_o !== 1'b1 || commit_o !== 1'b0) begin bad++; $display("FAIL cmd_err: got e=%b c=%b want e=1 c=0", error_o, commit_o); end
        total++; if (errCode_o !== 2'd3) begin bad++; $display("FAIL cmd_code: got %0d want 3", errCode_o); end
        total++; if (rxReady_o !== 1'b1 || txValid_o !== 1'b0) begin bad++; $display("FAIL cmd_idle: got r=%b v=%b want r=1 v=0", rxReady_o, txValid_o); end
        tick();
        total++; if (error_o !== 1'b0) begin bad++; $display("FAIL cmd_pulse: got %b want 0", error_o); end
    endtask

    task automatic test_reset_mid_frame();
        send(8'hA5);
        total++; if (errCode_o !== 2'd0) begin bad++; $display("FAIL mid_start: got %0d want 0", errCode_o); end
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (CR_bus_o !== RST_CFG) begin bad++; $display("FAIL mid_cr: got %h want %h", CR_bus_o, RST_CFG); end
        for (int i = 0; i < 20; i++) begin
            total++; if (commit_o !== 1'b0 || error_o !== 1'b0) begin bad++; $display("FAIL mid_quiet%0d: got c=%b e=%b want 0 0", i, commit_o, error_o); end
            tick();
        end
        total++; if (CR_bus_o !== RST_CFG || errCode_o !== 2'd0) begin bad++; $display("FAIL mid_after: got %h c=%0d want %h c=0", CR_bus_o, errCode_o, RST_CFG); end
    endtask

    task automatic test_back_to_back();
        send(8'hA5);
        for (int i = 0; i < 8; i++) send(8'hFF);
        send(8'h00);
        total++; if (commit_o !== 1'b1 || CR_bus_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL b2b_1: got c=%b cr=%h want c=1 cr=ffffffffffffffff", commit_o, CR_bus_o); end
        send(8'hA5);
        total++; if (commit_o !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", commit_o); end
        for (int i = 0; i < 8; i++) send(8'h00);
        send(8'h00);
        total++; if (commit_o !== 1'b1 || CR_bus_o !== 64'h0) begin bad++; $display("FAIL b2b_2: got c=%b cr=%h want c=1 cr=0", commit_o, CR_bus_o); end
    endtask

    initial begin
        rst_n     = 1'b0;
        rxData_i  = 8'h00;
        rxValid_i = 1'b0;
        txReady_i = 1'b0;
        test_reset();
        test_write();
        test_bad_checksum();
        test_readback();
        test_timeout();
        test_bad_cmd();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
